// File: rtl/cp0_pkg.sv
// Shared constants and the exception-type decoder for the CP0 register file.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  // Read-only identification registers
  localparam logic [31:0] PRID_VAL   = 32'h004C_0102;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

  // Resolved exception types coming from the priority encoder
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Cause.ExcCode values
  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  // Status reset value (BEV=1) and software-writable bit masks
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam int          STATUS_EXL   = 1;
  localparam int          CAUSE_BD     = 31;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    logic       load_badvaddr;
  } exc_decode_t;

  // Map an exception type to its ExcCode; unknown types decode as "no exception".
  function automatic exc_decode_t decode_exc(input logic [31:0] etype);
    exc_decode_t r;
    case (etype)
      EXC_INT:  r = '{1'b1, CODE_INT,  1'b0};
      EXC_ADEL: r = '{1'b1, CODE_ADEL, 1'b1};
      EXC_ADES: r = '{1'b1, CODE_ADES, 1'b1};
      EXC_SYS:  r = '{1'b1, CODE_SYS,  1'b0};
      EXC_BP:   r = '{1'b1, CODE_BP,   1'b0};
      EXC_RI:   r = '{1'b1, CODE_RI,   1'b0};
      EXC_OV:   r = '{1'b1, CODE_OV,   1'b0};
      default:  r = '{1'b0, 5'h00,     1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, timer_int_o latches
// on a Count==Compare match and is cleared only by rewriting Compare.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  // Next-state for tick, Count, Compare and the sticky timer interrupt
  always_comb begin
    tick_d      = ~tick_q;
    count_d     = count_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (count_we_i) begin
      count_d = data_i;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    // A Compare write clears the interrupt even if a match happens this cycle
    if (compare_we_i) begin
      compare_d   = data_i;
      timer_int_d = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end else begin
      timer_int_d = timer_int_q;
    end
  end

  // Timer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 1'b0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MTC0/MFC0 access, exception/ERET bookkeeping
// for Status, Cause, EPC and BadVAddr, plus the Count/Compare timer.
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  exc_decode_t exc_s;
  logic        eret_s;
  logic        count_we_s, compare_we_s;

  assign count_we_s   = we_i && (waddr_i == REG_COUNT);
  assign compare_we_s = we_i && (waddr_i == REG_COMPARE);

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (count_we_s),
    .compare_we_i (compare_we_s),
    .data_i       (data_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .timer_int_o  (timer_int_o)
  );

  // Next-state: MTC0 writes first, then exception/ERET updates override their fields
  always_comb begin
    exc_s      = decode_exc(excepttype_i);
    eret_s     = (excepttype_i == EXC_ERET);
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    cause_d[15:10] = int_i;

    if (we_i && (waddr_i == REG_STATUS)) begin
      status_d = data_i & STATUS_WMASK;
    end else begin
      status_d = status_q;
    end
    if (we_i && (waddr_i == REG_CAUSE)) begin
      cause_d = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    end else begin
      cause_d = cause_d;
    end
    if (we_i && (waddr_i == REG_EPC)) begin
      epc_d = data_i;
    end else begin
      epc_d = epc_q;
    end

    if (exc_s.valid) begin
      cause_d[6:2]          = exc_s.code;
      status_d[STATUS_EXL]  = 1'b1;
      // A nested exception keeps the EPC/BD of the original one
      if (!status_q[STATUS_EXL]) begin
        epc_d             = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                              : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end else begin
        epc_d             = epc_d;
      end
      if (exc_s.load_badvaddr) begin
        badvaddr_d = bad_addr_i;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (eret_s) begin
      status_d[STATUS_EXL] = 1'b0;
    end else begin
      status_d = status_d;
    end
  end

  // Architectural CP0 registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // MFC0 read mux; no bypass from a same-cycle write
  always_comb begin
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_q;
      REG_COUNT:    data_o = count_o;
      REG_COMPARE:  data_o = compare_o;
      REG_STATUS:   data_o = status_q;
      REG_CAUSE:    data_o = cause_q;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID_VAL;
      REG_CONFIG:   data_o = CONFIG_VAL;
      default:      data_o = 32'd0;
    endcase
  end

  assign status_o   = status_q;
  assign cause_o    = cause_q;
  assign epc_o      = epc_q;
  assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i, current_inst_addr_i, bad_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: Count is the last loaded value plus half the cycles since the load
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_compare, m_cbase;
  int unsigned m_n;
  logic        m_tint;

  cp0_regfile dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .raddr_i             (raddr_i),
    .data_i              (data_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .bad_addr_i          (bad_addr_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .badvaddr_o          (badvaddr_o),
    .timer_int_o         (timer_int_o)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_n >> 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h004C_0102;
      5'd16:   return 32'h0000_8000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic idle();
    rst = 1'b0; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
    excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
    is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
  endtask

  task automatic compare_all();
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause);
    chk("epc", epc_o, m_epc);
    chk("badvaddr", badvaddr_o, m_badv);
    chk("count", count_o, m_count());
    chk("compare", compare_o, m_compare);
    chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
    chk("data_o", data_o, m_read(raddr_i));
  endtask

  // Advance one clock: model computes from pre-edge state and current inputs
  task automatic step();
    logic [31:0] cnt, st, ca, ep, bv, cm, cb;
    int unsigned n;
    logic ti, exc, ld_bv;
    logic [4:0] code;
    cnt = m_count();
    st = m_status; ca = m_cause; ep = m_epc; bv = m_badv;
    cm = m_compare; cb = m_cbase; n = m_n + 1; ti = m_tint;
    exc = 1'b1; ld_bv = 1'b0; code = 5'd0;
    case (excepttype_i)
      32'h01: code = 5'h00;
      32'h04: begin code = 5'h04; ld_bv = 1'b1; end
      32'h05: begin code = 5'h05; ld_bv = 1'b1; end
      32'h08: code = 5'h08;
      32'h09: code = 5'h09;
      32'h0a: code = 5'h0a;
      32'h0c: code = 5'h0c;
      default: exc = 1'b0;
    endcase
    if (m_compare != 32'd0 && cnt == m_compare) ti = 1'b1;
    ca[15:10] = int_i;
    if (we_i) begin
      case (waddr_i)
        5'd9:  begin cb = data_i; n = 0; end
        5'd11: begin cm = data_i; ti = 1'b0; end
        5'd12: st = data_i & 32'h0040_FF03;
        5'd13: ca[9:8] = data_i[9:8];
        5'd14: ep = data_i;
        default: ;
      endcase
    end
    if (exc) begin
      ca[6:2] = code;
      st[1] = 1'b1;
      if (!m_status[1]) begin
        ep = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
        ca[31] = is_in_delayslot_i;
      end
      if (ld_bv) bv = bad_addr_i;
    end else if (excepttype_i == 32'h0e) begin
      st[1] = 1'b0;
    end
    if (rst) begin
      st = 32'h0040_0000; ca = 32'd0; ep = 32'd0; bv = 32'd0;
      cm = 32'd0; cb = 32'd0; n = 0; ti = 1'b0;
    end
    @(posedge clk);
    #1;
    m_status = st; m_cause = ca; m_epc = ep; m_badv = bv;
    m_compare = cm; m_cbase = cb; m_n = n; m_tint = ti;
    compare_all();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we_i = 1'b1; waddr_i = a; data_i = d;
  endtask

  task automatic raise(input logic [31:0] t, input logic [31:0] pc,
                       input logic ds, input logic [31:0] ba);
    idle(); excepttype_i = t; current_inst_addr_i = pc;
    is_in_delayslot_i = ds; bad_addr_i = ba;
  endtask

  localparam int NREG = 9;
  logic [4:0]  regs  [NREG] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
  logic [31:0] etypes [12] = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a,
                               32'h0c, 32'h0e, 32'h03, 32'h20, 32'h0e, 32'h08};

  initial begin
    bit seen;
    idle(); raddr_i = 5'd12; int_i = 6'd0; rst = 1'b1;
    m_status = 32'hx; m_cause = 32'hx; m_epc = 32'hx; m_badv = 32'hx;
    m_compare = 32'hx; m_cbase = 32'hx; m_n = 0; m_tint = 1'bx;
    step(); step();
    idle();

    // Reset values through the read port, no clock in between
    for (int i = 0; i < NREG; i++) begin
      raddr_i = regs[i]; #1;
      chk("rd_reset", data_o, m_read(regs[i]));
    end
    raddr_i = 5'd12; #1; chk("rst_status", data_o, 32'h0040_0000);
    raddr_i = 5'd15; #1; chk("rst_prid", data_o, 32'h004C_0102);
    raddr_i = 5'd16; #1; chk("rst_config", data_o, 32'h0000_8000);
    raddr_i = 5'd14; #1; chk("rst_epc", data_o, 32'h0000_0000);

    // Overflow in a delay slot, then a nested syscall
    raise(32'h0c, 32'hBFC0_0100, 1'b1, 32'd0); step();
    chk("ov_epc", epc_o, 32'hBFC0_00FC);
    chk("ov_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("ov_code", {27'd0, cause_o[6:2]}, 32'h0c);
    chk("ov_exl", {31'd0, status_o[1]}, 32'd1);
    raise(32'h08, 32'h8000_0040, 1'b0, 32'd0); step();
    chk("nest_epc", epc_o, 32'hBFC0_00FC);
    chk("nest_code", {27'd0, cause_o[6:2]}, 32'h08);

    // Address error loads BadVAddr, ERET clears only EXL
    raise(32'h04, 32'h8000_0080, 1'b0, 32'h8000_0003); step();
    chk("adel_bv", badvaddr_o, 32'h8000_0003);
    chk("adel_code", {27'd0, cause_o[6:2]}, 32'h04);
    raise(32'h0e, 32'h1234_5678, 1'b0, 32'd0); step();
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
    chk("eret_epc", epc_o, 32'hBFC0_00FC);

    // Timer match and clear
    mtc0(5'd9, 32'd0); step();
    mtc0(5'd11, 32'd5); step();
    idle(); seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = timer_int_o;
    end
    chk("timer_rise", {31'd0, seen}, 32'd1);
    mtc0(5'd11, 32'd0); step();
    chk("timer_clear", {31'd0, timer_int_o}, 32'd0);

    // Same-cycle MTC0 Status and exception: exception owns EXL, write owns IE
    mtc0(5'd12, 32'h0000_FF01); step();
    mtc0(5'd12, 32'h0000_0000);
    excepttype_i = 32'h08; current_inst_addr_i = 32'h8000_0100; step();
    chk("conf_exl", {31'd0, status_o[1]}, 32'd1);
    chk("conf_ie", {31'd0, status_o[0]}, 32'd0);

    // Count wrap and interrupt sampling
    mtc0(5'd9, 32'hFFFF_FFFF); step();
    idle(); step(); step();
    chk("count_wrap", count_o, 32'd0);
    int_i = 6'b100001; step();
    chk("cause_ip", {26'd0, cause_o[15:10]}, 32'b100001);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 299) == 0);
      raddr_i = 5'($urandom_range(0, 31));
      int_i = 6'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        we_i = 1'b1;
        waddr_i = regs[$urandom_range(0, NREG - 1)];
        case (waddr_i)
          5'd9:    data_i = 32'($urandom_range(0, 30));
          5'd11:   data_i = 32'($urandom_range(0, 40));
          default: data_i = $urandom;
        endcase
      end
      if ($urandom_range(0, 9) < 3) begin
        excepttype_i = etypes[$urandom_range(0, 11)];
        current_inst_addr_i = {$urandom, 2'b00} & 32'hFFFF_FFFC;
        is_in_delayslot_i = 1'($urandom);
        bad_addr_i = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the five-stage MIPS pipeline. Sits directly downstream of the exception priority encoder in the MEM stage: it consumes the resolved 32-bit exception type, PC, delay-slot flag and faulting address, and updates EPC, Cause, Status and BadVAddr on the clock edge. It also services MTC0/MFC0 accesses and runs the Count/Compare timer. Its registered Status and Cause outputs feed back into the exception encoder's interrupt check.

## Interface
- PRID_VAL, 32'h004C_0102, constant returned for PRId (reg 15)
- CONFIG_VAL, 32'h0000_8000, constant returned for Config (reg 16)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 destination register number
- raddr_i  in  5  MFC0 source register number
- data_i  in  32  MTC0 write data
- int_i  in  6  hardware interrupt lines, sampled into Cause.IP[7:2]
- excepttype_i  in  32  resolved exception type (0 = none)
- current_inst_addr_i  in  32  PC of the MEM-stage instruction
- is_in_delayslot_i  in  1  MEM-stage instruction is in a branch delay slot
- bad_addr_i  in  32  faulting address for AdEL/AdES
- data_o  out  32  MFC0 read data (combinational)
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  registered register values
- timer_int_o  out  1  timer interrupt; the top level ORs it into int_i[5]

## Operation
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config. Unmapped reads return 0; unmapped writes are ignored.
- Writable bits: Status[22] BEV, [15:8] IM, [1] EXL, [0] IE (others read 0). Cause[9:8] IP1..0 only. Count, Compare and EPC are fully writable. BadVAddr, PRId and Config are read-only.
- Cause[15:10] <= int_i every cycle.
- Exception handling when excepttype_i is 0x01/0x04/0x05/0x08/0x09/0x0a/0x0c:
  - Cause.ExcCode[6:2] <= 0x00/0x04/0x05/0x08/0x09/0x0a/0x0c respectively.
  - If Status.EXL==0: EPC <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i; Cause.BD[31] <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - For 0x04 and 0x05 only: BadVAddr <= bad_addr_i.
- ERET (excepttype_i == 0x0e): Status.EXL <= 0 only. Any other non-zero code is ignored.
- Conflicts: an exception or ERET update overrides an MTC0 write to the same field in the same cycle. Unaffected fields still accept the write.
- Timer:
  - 1-bit tick flop toggles every cycle; Count increments when tick==1, i.e. every second cycle, with 32-bit wrap.
  - An MTC0 to Count loads data_i, suppresses that cycle's increment, and resets tick to 0.
  - timer_int_o sets when Compare != 0 and Count == Compare (pre-edge values). It stays set until an MTC0 to Compare clears it; the clear wins over a simultaneous set.
- Read path: data_o = current register value selected by raddr_i. There is no write-to-read bypass; forwarding is the pipeline's job.

## Timing
- Reset values: Status 32'h0040_0000 (BEV=1), all other registers 0, tick 0, timer_int_o 0.
- All register updates take effect at the rising edge. Updated status_o/cause_o/epc_o are visible one cycle after the event.
- Reset asserted mid-operation overrides every pending write, exception and tick in that cycle.
- Back-to-back exceptions: the second sees EXL=1 and preserves EPC.
- Count == 32'hFFFF_FFFF wraps to 0 on the next increment.

## Structure
- Shared package cp0_pkg holds:
  - register number constants
  - excepttype codes (0x01, 0x04, 0x05, 0x08, 0x09, 0x0a, 0x0c, 0x0e)
  - ExcCode values
  - Status reset constant and writable-bit masks for Status and Cause
- One sub-module cp0_timer owns tick, Count, Compare and timer_int_o. It takes the write strobes for Count and Compare.

## Test plan
- Reset, then read all registers → Status=0x0040_0000, PRId=0x004C_0102, Config=0x0000_8000, all others 0.
- excepttype_i=0x0c, PC=0xBFC0_0100, delayslot=1 → EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=0x0c, EXL=1. A second 0x08 the next cycle leaves EPC unchanged and sets ExcCode=0x08.
- excepttype_i=0x04 with bad_addr_i=0x8000_0003 → BadVAddr=0x8000_0003, ExcCode=0x04. Then 0x0e (ERET) → EXL=0, EPC unchanged.
- MTC0 Compare=5 with Count=0 → timer_int_o rises after Count reaches 5 (about 10 cycles). MTC0 Compare=0 → timer_int_o=0 the next cycle.
- Same-cycle MTC0 Status=0x0000_0000 and excepttype_i=0x08 → EXL=1 (exception wins), IE=0 (write applied).
- MTC0 Count=0xFFFF_FFFF → reads 0 two cycles later (wrap). int_i=6'b100001 → Cause[15:10]=6'b100001 the next cycle.
